// File: rtl/dct8_pkg.sv
// rtl/dct8_pkg.sv - Loeffler coefficient set, internal width and saturation helper for dct8_1d_pipe.
package dct8_pkg;

  localparam int A = 35;
  localparam int B = 84;
  localparam int C = 53;
  localparam int D = 35;
  localparam int E = 63;
  localparam int F = 12;
  localparam int P = 6;

  // Headroom for the widest product/sum chain, so nothing can overflow before saturation.
  function automatic int int_w(input int in_w);
    return in_w + 12;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/dct8_sat_shift.sv
// rtl/dct8_sat_shift.sv - optional round-half-up (DCT8_ROUND_EN), arithmetic shift and saturation of one coefficient.
module dct8_sat_shift
  import dct8_pkg::*;
#(
  parameter int IN_W  = 28,
  parameter int SHIFT = 6,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  d,
  output logic signed [OUT_W-1:0] q
);

  // (1 << SHIFT) >> 1 gives half an LSB of the result, and zero when SHIFT is 0.
`ifdef DCT8_ROUND_EN
  localparam logic signed [63:0] RND = (64'sd1 <<< SHIFT) >>> 1;
`else
  localparam logic signed [63:0] RND = 64'sd0;
`endif

  assign q = OUT_W'(sat((64'(d) + RND) >>> SHIFT, OUT_W));

endmodule

// File: rtl/dct8_1d_pipe.sv
// rtl/dct8_1d_pipe.sv - 3-stage 8-point 1-D Loeffler DCT with global-enable stall and row framing.
// Define DCT8_ROUND_EN to round shifted outputs half up instead of flooring.
module dct8_1d_pipe
  import dct8_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12,
  parameter int SH    = 6
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_x0,
  input  logic signed [IN_W-1:0]  in_x1,
  input  logic signed [IN_W-1:0]  in_x2,
  input  logic signed [IN_W-1:0]  in_x3,
  input  logic signed [IN_W-1:0]  in_x4,
  input  logic signed [IN_W-1:0]  in_x5,
  input  logic signed [IN_W-1:0]  in_x6,
  input  logic signed [IN_W-1:0]  in_x7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_y0,
  output logic signed [OUT_W-1:0] out_y1,
  output logic signed [OUT_W-1:0] out_y2,
  output logic signed [OUT_W-1:0] out_y3,
  output logic signed [OUT_W-1:0] out_y4,
  output logic signed [OUT_W-1:0] out_y5,
  output logic signed [OUT_W-1:0] out_y6,
  output logic signed [OUT_W-1:0] out_y7,
  output logic [2:0]              out_row,
  output logic                    out_last
);

  localparam int IW = int_w(IN_W);
  localparam logic signed [IW-1:0] KA = IW'(A);
  localparam logic signed [IW-1:0] KB = IW'(B);
  localparam logic signed [IW-1:0] KC = IW'(C);
  localparam logic signed [IW-1:0] KD = IW'(D);
  localparam logic signed [IW-1:0] KE = IW'(E);
  localparam logic signed [IW-1:0] KF = IW'(F);
  localparam logic signed [IW-1:0] KP = IW'(P);

  // One enable for every stage: the whole pipe moves unless the output is held.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic signed [IN_W-1:0] x [8];
  assign x[0] = in_x0;
  assign x[1] = in_x1;
  assign x[2] = in_x2;
  assign x[3] = in_x3;
  assign x[4] = in_x4;
  assign x[5] = in_x5;
  assign x[6] = in_x6;
  assign x[7] = in_x7;

  // S1: butterflies
  logic                 v1;
  logic signed [IN_W:0] vp [4];
  logic signed [IN_W:0] vn [4];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        vp[k] <= '0;
        vn[k] <= '0;
      end
    end else if (adv) begin
      v1 <= in_valid;
      for (int k = 0; k < 4; k++) begin
        vp[k] <= (IN_W+1)'(x[k]) + (IN_W+1)'(x[7-k]);
        vn[k] <= (IN_W+1)'(x[k]) - (IN_W+1)'(x[7-k]);
      end
    end
  end

  // S2: even terms and odd rotations
  logic signed [IW-1:0] pn [4];
  always_comb begin
    for (int k = 0; k < 4; k++) pn[k] = IW'(vn[k]);
  end

  logic                   v2;
  logic signed [IN_W+1:0] e [4];
  logic signed [IW-1:0]   t [4];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        e[k] <= '0;
        t[k] <= '0;
      end
    end else if (adv) begin
      v2   <= v1;
      e[0] <= (IN_W+2)'(vp[0]) + (IN_W+2)'(vp[3]);
      e[1] <= (IN_W+2)'(vp[1]) + (IN_W+2)'(vp[2]);
      e[2] <= (IN_W+2)'(vp[0]) - (IN_W+2)'(vp[3]);
      e[3] <= (IN_W+2)'(vp[1]) - (IN_W+2)'(vp[2]);
      t[0] <= KC * pn[0] - KD * pn[3];
      t[1] <= KE * pn[2] + KF * pn[1];
      t[2] <= KD * pn[0] + KC * pn[3];
      t[3] <= KE * pn[1] - KF * pn[2];
    end
  end

  // S3: output sums at full precision, then per-coefficient shift and saturation
  logic signed [IW-1:0] ex [4];
  logic signed [IW-1:0] s  [8];

  always_comb begin
    for (int k = 0; k < 4; k++) ex[k] = IW'(e[k]);
    s[0] = ex[0] + ex[1];
    s[4] = ex[0] - ex[1];
    s[2] = KB * ex[2] + KA * ex[3];
    s[6] = KA * ex[2] - KB * ex[3];
    s[1] = t[0] + t[1] + t[2] + t[3];
    s[7] = (t[0] + t[1]) - (t[2] + t[3]);
    s[3] = KP * (t[0] - t[1]);
    s[5] = KP * (t[2] - t[3]);
  end

  logic signed [OUT_W-1:0] sq [8];

  for (genvar i = 0; i < 8; i++) begin : g_sat
    localparam int SHV = (i == 0 || i == 4) ? 0 : ((i == 3 || i == 5) ? SH + 2 : SH);
    dct8_sat_shift #(
      .IN_W (IW),
      .SHIFT(SHV),
      .OUT_W(OUT_W)
    ) u_sat (
      .d(s[i]),
      .q(sq[i])
    );
  end

  logic signed [OUT_W-1:0] y [8];
  logic [2:0]              row;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      for (int k = 0; k < 8; k++) y[k] <= '0;
    end else if (adv) begin
      out_valid <= v2;
      for (int k = 0; k < 8; k++) y[k] <= sq[k];
    end
  end

  // Row index advances per delivered vector and wraps naturally at 8.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      row <= 3'd0;
    else if (out_valid && out_ready)
      row <= row + 3'd1;
  end

  assign out_row  = row;
  assign out_last = out_valid & (row == 3'd7);

  assign out_y0 = y[0];
  assign out_y1 = y[1];
  assign out_y2 = y[2];
  assign out_y3 = y[3];
  assign out_y4 = y[4];
  assign out_y5 = y[5];
  assign out_y6 = y[6];
  assign out_y7 = y[7];

endmodule

// File: tb/tb_dct8_1d_pipe.sv
// tb/tb_dct8_1d_pipe.sv - directed self-checking bench for dct8_1d_pipe.
module tb_dct8_1d_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 12;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic [2:0] out_row;
  logic signed [IN_W-1:0]  xi [8];
  logic signed [OUT_W-1:0] yo [8];

  int errors = 0;
  int checks = 0;
  int vx [8];
  int ve [8];

  always #5 clk = ~clk;

  dct8_1d_pipe dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(xi[0]), .in_x1(xi[1]), .in_x2(xi[2]), .in_x3(xi[3]),
    .in_x4(xi[4]), .in_x5(xi[5]), .in_x6(xi[6]), .in_x7(xi[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(yo[0]), .out_y1(yo[1]), .out_y2(yo[2]), .out_y3(yo[3]),
    .out_y4(yo[4]), .out_y5(yo[5]), .out_y6(yo[6]), .out_y7(yo[7]),
    .out_row(out_row), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_x(input int v);
    for (int i = 0; i < 8; i++) xi[i] = IN_W'(v);
  endtask

  // Drive vx for one cycle and expect ve exactly three edges later.
  task automatic run_vec(input string tag);
    @(negedge clk);
    for (int i = 0; i < 8; i++) xi[i] = IN_W'(vx[i]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ".lat2"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ".lat3"}, out_valid, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("%s.y%0d", tag, i), yo[i], ve[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int sent, recvd, expv;
  int expq [$];
  bit stall_prev;
  logic signed [OUT_W-1:0] y0_prev;

  initial begin
    set_x(0);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_row", out_row, 0);
    chk("rst.out_last", out_last, 0);
    chk("rst.y0", yo[0], 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    vx = '{10, 10, 10, 10, 10, 10, 10, 10};
    ve = '{80, 0, 0, 0, 0, 0, 0, 0};
    run_vec("dc10");

    vx = '{100, 0, 0, 0, 0, 0, 0, 0};
`ifdef DCT8_ROUND_EN
    ve = '{100, 138, 131, 124, 100, 82, 55, 28};
`else
    ve = '{100, 137, 131, 124, 100, 82, 54, 28};
`endif
    run_vec("x0imp");

    vx = '{0, 0, 0, 0, 0, 0, 0, 100};
`ifdef DCT8_ROUND_EN
    ve = '{100, -137, 131, -124, 100, -82, 55, -28};
`else
    ve = '{100, -138, 131, -125, 100, -83, 54, -29};
`endif
    run_vec("x7imp");

    vx = '{0, 100, 0, 0, 0, 0, 0, 0};
`ifdef DCT8_ROUND_EN
    ve = '{100, 117, 55, -28, -100, -148, -131, -80};
`else
    ve = '{100, 117, 54, -29, -100, -148, -132, -80};
`endif
    run_vec("x1imp");

    vx = '{2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000};
    ve = '{2047, 0, 0, 0, 0, 0, 0, 0};
    run_vec("satpos");

    vx = '{-2000, -2000, -2000, -2000, -2000, -2000, -2000, -2000};
    ve = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    run_vec("satneg");

    // Streaming with back-pressure: vector k is all k, so y0 = 8k identifies it.
    do_reset();
    sent = 0;
    recvd = 0;
    stall_prev = 1'b0;
    y0_prev = '0;
    for (int cyc = 0; cyc < 600 && recvd < 16; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        chk("stall.valid", out_valid, 1);
        chk("stall.y0", yo[0], y0_prev);
      end
      out_ready = (cyc < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 16);
      set_x(sent + 1);
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(8 * (sent + 1));
        sent++;
      end
      if (out_valid && out_ready) begin
        expv = (expq.size() > 0) ? expq.pop_front() : -1;
        chk($sformatf("stream.y0[%0d]", recvd), yo[0], expv);
        chk($sformatf("stream.row[%0d]", recvd), out_row, recvd % 8);
        chk($sformatf("stream.last[%0d]", recvd), out_last, (recvd % 8) == 7);
        recvd++;
      end
      stall_prev = out_valid && !out_ready;
      y0_prev = yo[0];
    end
    chk("stream.count", recvd, 16);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("stream.no_dup", out_valid, 0);

    // Reset with three vectors in flight.
    vx = '{1, 1, 1, 1, 1, 1, 1, 1};
    ve = '{8, 0, 0, 0, 0, 0, 0, 0};
    run_vec("pre_rst");
    in_valid = 1'b1;
    set_x(5);
    repeat (3) @(negedge clk);
    chk("flight.row", out_row, 1);
    chk("flight.valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.out_row", out_row, 0);
    chk("midrst.out_last", out_last, 0);
    chk("midrst.y0", yo[0], 0);
    @(negedge clk);
    rstn = 1'b1;
    vx = '{3, 3, 3, 3, 3, 3, 3, 3};
    ve = '{24, 0, 0, 0, 0, 0, 0, 0};
    run_vec("post_rst");
    chk("post_rst.row", out_row, 0);
    chk("post_rst.last", out_last, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
